// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: func3 encodings and controller states.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_ctrl_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Width/lane decode: legality, byte enables, store lane replication and load extraction.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        legal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // func3[1:0] carries the access width for both signed and unsigned loads
  always_comb begin
    be    = '0;
    wdata = wr_data;
    legal = 1'b0;
    case (func3[1:0])
      2'b00: begin
        be    = 4'(4'b0001 << addr_lo);
        wdata = {4{wr_data[7:0]}};
        legal = 1'b1;
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
        legal = ~addr_lo[0];
      end
      2'b10: begin
        be    = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      default: legal = 1'b0;
    endcase
    if (is_store ? func3[2] : (func3[2] & func3[1])) legal = 1'b0;
  end

  always_comb begin
    load_ext = '0;
    case (func3)
      F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_ext = rdata;
      F3_BU:   load_ext = {24'd0, byte_lane};
      F3_HU:   load_ext = {16'd0, half_lane};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues one bus access per memory instruction and stalls the datapath until it completes.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         func3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               stall,
  output logic               misalign,
  output logic               bus_timeout,
  lsu_ctrl_if.master         bus
);

  lsu_state_e  state_q;
  logic [2:0]  func3_q;
  logic [1:0]  addr_lo_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [31:0] rd_data_q;
  logic        bus_timeout_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        req_in;
  logic        is_legal;
  logic [3:0]  is_be;
  logic [31:0] is_wdata;
  logic [31:0] is_ext_unused;
  logic [31:0] ld_ext;
  logic [3:0]  ld_be_unused;
  logic [31:0] ld_wdata_unused;
  logic        ld_legal_unused;

  assign req_in = mem_read | mem_write;

  lsu_ctrl_align u_issue_align (
    .is_store (mem_write),
    .func3    (func3),
    .addr_lo  (addr[1:0]),
    .wr_data  (wr_data),
    .rdata    (32'd0),
    .be       (is_be),
    .wdata    (is_wdata),
    .load_ext (is_ext_unused),
    .legal    (is_legal)
  );

  lsu_ctrl_align u_load_align (
    .is_store (1'b0),
    .func3    (func3_q),
    .addr_lo  (addr_lo_q),
    .wr_data  (32'd0),
    .rdata    (bus.bus_rdata),
    .be       (ld_be_unused),
    .wdata    (ld_wdata_unused),
    .load_ext (ld_ext),
    .legal    (ld_legal_unused)
  );

  // Gated by rst so reset clears them even while the datapath still presents a request
  assign stall    = ~rst & ((state_q == BUSY) | ((state_q == IDLE) & req_in & is_legal));
  assign misalign = ~rst & (state_q == IDLE) & req_in & ~is_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      func3_q       <= '0;
      addr_lo_q     <= '0;
      to_cnt_q      <= '0;
      rd_data_q     <= '0;
      bus_timeout_q <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus_timeout_q <= 1'b0;
          if (req_in && is_legal) begin
            func3_q   <= func3;
            addr_lo_q <= addr[1:0];
            to_cnt_q  <= '0;
            req_q     <= 1'b1;
            we_q      <= mem_write;
            addr_q    <= {addr[31:2], 2'b00};
            be_q      <= is_be;
            wdata_q   <= is_wdata;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ready) begin
            if (!we_q) rd_data_q <= ld_ext;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rd_data_q     <= '0;
            bus_timeout_q <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          bus_timeout_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data       = rd_data_q;
  assign bus_timeout   = bus_timeout_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the single-cycle datapath and a handshaked data-memory bus.
- Consumes the datapath's memory-op controls, func3, ALU-computed address and store data.
- Drives word-aligned bus transactions with byte enables, then returns aligned, sign/zero-extended load data.
- Stalls the datapath (freezes PC and register write) until the access completes, is rejected, or times out.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles bus_req may wait for bus_ready before the access aborts; legal range 1..65535.
- TO_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; wins if both are set.
- func3  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw.
- addr  in  32  effective byte address (ALU result).
- wr_data  in  32  store source (rs2 value).
- rd_data  out  32  extended load data to the writeback mux, registered.
- stall  out  1  hold PC and suppress regwrite while high.
- misalign  out  1  misaligned access or illegal func3 this cycle; combinational.
- bus_timeout  out  1  one-cycle pulse when an access aborts.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  write strobe, registered.
- bus_addr  out  32  {addr[31:2],2'b00}, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_ready  in  1  slave accepts or completes the access in this cycle.
- bus_rdata  in  32  read word; valid when bus_ready is high.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset asserted mid-access drops bus_req asynchronously and discards the access.
- States:
  - IDLE: a request is present when mem_read|mem_write is high. Legality checks:
    - lw/sw need addr[1:0]==0; lh/lhu/sh need addr[0]==0.
    - func3 011, 110, 111 are illegal for loads; func3 above 010 is illegal for stores.
  - IDLE, illegal request: misalign=1, stall=0, no bus activity, stay IDLE.
  - IDLE, legal request: stall=1 combinationally; latch bus_* registers, func3 and addr[1:0]; next state BUSY.
  - BUSY: stall=1; bus_req=1; bus_addr, bus_be, bus_wdata and bus_we stay stable. Timeout counter increments each cycle.
    - bus_ready=1: capture extended load data into rd_data (stores leave rd_data unchanged). Drop bus_req next cycle. Next state DONE.
    - Counter reaches TIMEOUT_CYCLES with no bus_ready: rd_data<=0, bus_timeout pulses, drop bus_req. Next state DONE.
    - If bus_ready and timeout coincide, bus_ready wins.
  - DONE: exactly one cycle with stall=0, so the datapath commits writeback and advances PC. Request inputs are ignored (they are the same instruction). Next state IDLE.
- Latency: minimum 3 cycles per legal access (IDLE→BUSY→DONE) with bus_ready high in the first BUSY cycle.
- Byte enables:
  - sb/lb/lbu: 1<<addr[1:0].
  - sh/lh/lhu: addr[1] ? 4'b1100 : 4'b0011.
  - sw/lw: 4'b1111.
  - Loads drive the same enables as stores of the same width.
- Store data: sb {4{wr_data[7:0]}}; sh {2{wr_data[15:0]}}; sw wr_data.
- Load extract, using the latched addr[1:0]: select the byte or half lane; lb/lh sign-extend, lbu/lhu zero-extend.
- No back-to-back issue: a new request is accepted only in IDLE.

Decomposition:
- lsu_pkg: func3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and a 2-bit state enum (IDLE, BUSY, DONE).
- lsu_align: combinational sub-module. Inputs func3, addr[1:0], wr_data, bus_rdata. Outputs be, wdata, load_ext, legal. Used twice: issue-side decode in IDLE and load-side extract at completion.

Test Plan:
- lw addr 0x0000_0010, bus_ready after 2 BUSY cycles, rdata 0xDEAD_BEEF → bus_addr 0x10, be 1111; stall high 3 cycles, then DONE; rd_data 0xDEAD_BEEF.
- lb addr 0x13, rdata 0x80FF_0000 → be 1000; rd_data 0xFFFF_FF80. lbu at the same address → rd_data 0x0000_0080.
- sh addr 0x22, wr_data 0x1234_ABCD → bus_we 1, be 1100, bus_wdata 0xABCD_ABCD; rd_data unchanged.
- lw addr 0x06, then lh addr 0x05 → misalign=1, stall=0, bus_req never asserts. func3 011 load → misalign=1.
- TIMEOUT_CYCLES=4, bus_ready held low → bus_req high 4 cycles, bus_timeout pulses once, rd_data 0, stall releases in DONE.
- rst asserted in BUSY mid-access → bus_req and stall drop immediately without a clock edge; after release, lw 0x10 completes normally.
